hazard_scheduler: RTL and testbench



---
 rtl/hazard_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_hazard_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard controller: RAW stall/bubble sequencing against a
// 3-entry writer scoreboard (EX/MEM/WB) plus a fixed branch/jump shadow.
module hazard_scheduler #(
  parameter int unsigned BR_BUBBLES = 3,
  parameter bit          WB_BYPASS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        ext_hold,
  output logic        stall,
  output logic        bubble,
  output logic        issue,
  output logic        state,
  output logic [15:0] stall_count
);

  localparam int unsigned REG_W    = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SH_W     = 3;
  localparam int unsigned SB_DEPTH = 3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rnum;
  } sb_entry_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]  count_q, count_d;
  sb_entry_t         sb_q [SB_DEPTH];
  sb_entry_t         sb_new;
  logic              sb_shift;
  logic              cnt_inc;
  logic              stall_c, bubble_c, issue_c;

  logic [REG_W-1:0]  rs, rt, rd;
  logic [REG_W-1:0]  src_a, src_b, dst;
  logic              use_a, use_b, use_dst, is_branch, is_jump;
  logic              raw_c;
  logic              unused_bits;

  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_bits = ^instr[10:0];

  // Opcode decode into source/destination register usage
  always_comb begin
    src_a     = rs;
    src_b     = rt;
    dst       = rd;
    use_a     = 1'b0;
    use_b     = 1'b0;
    use_dst   = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        use_a = 1'b1; use_b = 1'b1; use_dst = 1'b1; dst = rd;
      end
      OP_LW, OP_ADDI, OP_ORI: begin
        use_a = 1'b1; use_dst = 1'b1; dst = rt;
      end
      OP_SW: begin
        use_a = 1'b1; use_b = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use_a = 1'b1; use_b = 1'b1; is_branch = 1'b1;
      end
      OP_J:    is_jump = 1'b1;
      default: ;
    endcase
  end

  function automatic logic reg_hit(input logic [REG_W-1:0] r,
                                   input sb_entry_t e0,
                                   input sb_entry_t e1,
                                   input sb_entry_t e2);
    return (r != '0) &&
           ((e0.valid && (e0.rnum == r)) ||
            (e1.valid && (e1.rnum == r)) ||
            (!WB_BYPASS && e2.valid && (e2.rnum == r)));
  endfunction

  assign raw_c = instr_valid && (state_q == RUN) &&
                 ((use_a && reg_hit(src_a, sb_q[0], sb_q[1], sb_q[2])) ||
                  (use_b && reg_hit(src_b, sb_q[0], sb_q[1], sb_q[2])));

  // Next-state, handshake outputs and scoreboard/counter control
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    count_d   = count_q;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    issue_c   = 1'b0;
    sb_shift  = 1'b0;
    sb_new    = '0;
    cnt_inc   = 1'b0;
    case (state_q)
      RUN: begin
        if (ext_hold) begin
          stall_c = 1'b1;
        end else if (raw_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          sb_shift = 1'b1;
          cnt_inc  = 1'b1;
        end else if (!instr_valid) begin
          bubble_c = 1'b1;
          sb_shift = 1'b1;
        end else begin
          issue_c      = 1'b1;
          sb_shift     = 1'b1;
          sb_new.valid = use_dst && (dst != '0);
          sb_new.rnum  = dst;
          if (is_branch && (BR_BUBBLES != 0)) begin
            shadow_d = SH_W'(BR_BUBBLES);
            state_d  = SHADOW;
          end else if (is_jump) begin
            shadow_d = SH_W'(1);
            state_d  = SHADOW;
          end
        end
      end
      SHADOW: begin
        stall_c = 1'b1;
        if (!ext_hold) begin
          bubble_c = 1'b1;
          sb_shift = 1'b1;
          cnt_inc  = 1'b1;
          shadow_d = shadow_q - SH_W'(1);
          if (shadow_q <= SH_W'(1)) begin
            shadow_d = '0;
            state_d  = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (cnt_inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      shadow_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      if (sb_shift) begin
        sb_q[2] <= sb_q[1];
        sb_q[1] <= sb_q[0];
        sb_q[0] <= sb_new;
      end
    end
  end

  // Pipeline controls are held inactive while in reset
  assign stall       = rst_n & stall_c;
  assign bubble      = rst_n & bubble_c;
  assign issue       = rst_n & issue_c;
  assign state       = state_q;
  assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: vector table through an expected
// queue, plus hand sequences for WB_BYPASS=0/BR_BUBBLES=0, reset and saturation.
module tb_hazard_scheduler;

  localparam logic [31:0] I_LW    = 32'h8E080000;
  localparam logic [31:0] I_ADD   = 32'h01084820;
  localparam logic [31:0] I_ADDI0 = 32'h20000005;
  localparam logic [31:0] I_ADD0  = 32'h00004820;
  localparam logic [31:0] I_BEQ   = 32'h10220004;
  localparam logic [31:0] I_BEQ8  = 32'h11020004;
  localparam logic [31:0] I_J     = 32'h08000010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ext_hold;

  logic        stall_m, bubble_m, issue_m, state_m;
  logic [15:0] count_m;
  logic        stall_n, bubble_n, issue_n, state_n;
  logic [15:0] count_n;
  logic        stall_s, bubble_s, issue_s, state_s;
  logic [15:0] count_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.BR_BUBBLES(3), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .ext_hold(ext_hold), .stall(stall_m), .bubble(bubble_m), .issue(issue_m),
    .state(state_m), .stall_count(count_m));

  hazard_scheduler #(.BR_BUBBLES(0), .WB_BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .ext_hold(ext_hold), .stall(stall_n), .bubble(bubble_n), .issue(issue_n),
    .state(state_n), .stall_count(count_n));

  hazard_scheduler #(.BR_BUBBLES(7), .WB_BYPASS(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .ext_hold(ext_hold), .stall(stall_s), .bubble(bubble_s), .issue(issue_s),
    .state(state_s), .stall_count(count_s));

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        hold;
    logic        stall;
    logic        bubble;
    logic        issue;
    logic        st;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  function automatic vec_t mkv(input logic [31:0] i, input logic v, input logic h,
                               input logic s, input logic b, input logic is,
                               input logic st, input logic [15:0] c);
    vec_t r;
    r.instr = i; r.vld = v; r.hold = h;
    r.stall = s; r.bubble = b; r.issue = is; r.st = st; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [31:0] i, input logic v, input logic h);
    @(posedge clk);
    #1;
    instr = i; instr_valid = v; ext_hold = h;
    @(negedge clk);
  endtask

  // Reset with a live instruction applied, so forced-zero outputs are observable
  task automatic reset_all(input string tag);
    rst_n = 1'b0; instr = I_LW; instr_valid = 1'b1; ext_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, ".rst.stall"},  16'(stall_m),  16'd0);
    chk({tag, ".rst.bubble"}, 16'(bubble_m), 16'd0);
    chk({tag, ".rst.issue"},  16'(issue_m),  16'd0);
    chk({tag, ".rst.state"},  16'(state_m),  16'd0);
    chk({tag, ".rst.count"},  count_m,       16'd0);
    chk({tag, ".rst.issue_n"}, 16'(issue_n), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; instr = '0; instr_valid = 1'b0;
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; ext_hold = 1'b0;

    //           instr    vld   hold  stall bub  iss  st   cnt
    vecs.push_back(mkv(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mkv(I_LW,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mkv(I_ADDI0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mkv(I_ADD0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mkv(I_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5));
    vecs.push_back(mkv(I_J,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5));
    vecs.push_back(mkv(I_J,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5));
    vecs.push_back(mkv(I_J,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5));
    vecs.push_back(mkv(I_J,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd5));
    vecs.push_back(mkv(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd6));
    vecs.push_back(mkv(I_ADD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6));
    vecs.push_back(mkv(I_LW,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd6));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8));
    vecs.push_back(mkv(I_LW,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8));
    vecs.push_back(mkv(I_ADDI0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd8));
    vecs.push_back(mkv(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd9));
    vecs.push_back(mkv(I_LW,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd9));
    vecs.push_back(mkv(I_BEQ8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd9));
    vecs.push_back(mkv(I_BEQ8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd10));
    vecs.push_back(mkv(I_BEQ8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd11));
    vecs.push_back(mkv(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd11));
    vecs.push_back(mkv(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd12));
    vecs.push_back(mkv(32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd13));
    vecs.push_back(mkv(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd14));

    // Main table on BR_BUBBLES=3, WB_BYPASS=1
    reset_all("tbl");
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      instr = vecs[i].instr; instr_valid = vecs[i].vld; ext_hold = vecs[i].hold;
      expq.push_back(vecs[i]);
      @(negedge clk);
      e = expq.pop_front();
      chk($sformatf("v%0d.stall", i),  16'(stall_m),  16'(e.stall));
      chk($sformatf("v%0d.bubble", i), 16'(bubble_m), 16'(e.bubble));
      chk($sformatf("v%0d.issue", i),  16'(issue_m),  16'(e.issue));
      chk($sformatf("v%0d.state", i),  16'(state_m),  16'(e.st));
      chk($sformatf("v%0d.count", i),  count_m,       e.cnt);
    end

    // WB_BYPASS=0: three RAW cycles; BR_BUBBLES=0: no shadow
    reset_all("nb");
    drv(I_LW, 1'b1, 1'b0);   chk("nb.lw.issue", 16'(issue_n), 16'd1);
    drv(I_ADD, 1'b1, 1'b0);  chk("nb.raw1.stall", 16'(stall_n), 16'd1);
                             chk("nb.raw1.bubble", 16'(bubble_n), 16'd1);
    drv(I_ADD, 1'b1, 1'b0);  chk("nb.raw2.stall", 16'(stall_n), 16'd1);
    drv(I_ADD, 1'b1, 1'b0);  chk("nb.raw3.stall", 16'(stall_n), 16'd1);
                             chk("nb.raw3.issue", 16'(issue_n), 16'd0);
    drv(I_ADD, 1'b1, 1'b0);  chk("nb.add.issue", 16'(issue_n), 16'd1);
                             chk("nb.add.count", count_n, 16'd3);
    drv(I_BEQ, 1'b1, 1'b0);  chk("nb.beq.issue", 16'(issue_n), 16'd1);
    drv(I_ADD0, 1'b1, 1'b0); chk("nb.next.issue", 16'(issue_n), 16'd1);
                             chk("nb.next.state", 16'(state_n), 16'd0);
                             chk("nb.next.count", count_n, 16'd3);

    // Reset pulse in the middle of a load-use stall
    reset_all("mid");
    drv(I_LW, 1'b1, 1'b0);   chk("mid.lw.issue", 16'(issue_m), 16'd1);
    drv(I_ADD, 1'b1, 1'b0);  chk("mid.raw.stall", 16'(stall_m), 16'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid.inrst.stall",  16'(stall_m),  16'd0);
    chk("mid.inrst.bubble", 16'(bubble_m), 16'd0);
    chk("mid.inrst.issue",  16'(issue_m),  16'd0);
    chk("mid.inrst.count",  count_m,       16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid.post.issue", 16'(issue_m), 16'd1);
    chk("mid.post.stall", 16'(stall_m), 16'd0);

    // Saturation on BR_BUBBLES=7: 9362 branch periods of 8 cycles give 65534
    reset_all("sat");
    @(posedge clk);
    #1;
    instr = I_BEQ; instr_valid = 1'b1;
    repeat (9362 * 8) @(posedge clk);
    #1 instr = I_LW;
    @(negedge clk);
    chk("sat.pre.count", count_s, 16'd65534);
    chk("sat.pre.issue", 16'(issue_s), 16'd1);
    drv(I_ADD, 1'b1, 1'b0);  chk("sat.raw1.stall", 16'(stall_s), 16'd1);
                             chk("sat.raw1.count", count_s, 16'd65534);
    drv(I_ADD, 1'b1, 1'b0);  chk("sat.raw2.stall", 16'(stall_s), 16'd1);
                             chk("sat.raw2.count", count_s, 16'hFFFF);
    drv(I_ADD, 1'b1, 1'b0);  chk("sat.hold.count", count_s, 16'hFFFF);
                             chk("sat.add.issue", 16'(issue_s), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
